// File: rtl/awgn_channel_if.sv
// Symbol input and noisy-symbol output streams of the AWGN channel stage.
interface awgn_channel_if #(
  parameter int DATA_W = 16
) ();
  logic signed [DATA_W-1:0] sym_in;
  logic                     sym_valid;
  logic                     sym_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output sym_in, sym_valid, out_ready,
    input  sym_ready, out_data, out_valid
  );

  modport slave (
    input  sym_in, sym_valid, out_ready,
    output sym_ready, out_data, out_valid
  );
endinterface

// File: rtl/awgn_channel.sv
// Adds scaled Gaussian noise to a symbol stream through a 3-stage stall-together
// pipeline, with a warm-up interlock covering the upstream generator's fill latency.
module awgn_channel #(
  parameter int DATA_W      = 16,
  parameter int SCALE_SHIFT = 16,
  parameter int WARMUP      = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] awgn_in,
  input  logic        [15:0] noise_scale,
  input  logic               noise_en,
  awgn_channel_if.slave      bus,
  output logic        [31:0] out_count,
  output logic        [15:0] sat_count
);

  localparam int WU_W  = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int SUM_W = (DATA_W + 18 > 34) ? DATA_W + 18 : 34;
  localparam logic signed [SUM_W-1:0] MAX_V = $signed((SUM_W'(1) << (DATA_W - 1)) - SUM_W'(1));
  localparam logic signed [SUM_W-1:0] MIN_V = -MAX_V - SUM_W'(1);

  logic [WU_W-1:0] wu_cnt;
  logic            warm;
  logic            adv;
  logic            accept;

  logic signed [DATA_W-1:0] s1_sym;
  logic signed [15:0]       s1_noise;
  logic        [15:0]       s1_scale;
  logic                     s1_valid;

  logic signed [32:0]       product;
  logic signed [32:0]       noise_shifted;
  logic signed [DATA_W-1:0] s2_sym;
  logic signed [32:0]       s2_noise;
  logic                     s2_valid;

  logic signed [SUM_W-1:0]  sum;
  logic                     sat_hi;
  logic                     sat_lo;
  logic signed [DATA_W-1:0] clamped;
  logic signed [DATA_W-1:0] s3_data;
  logic                     s3_valid;

  assign warm          = (wu_cnt == WU_W'(WARMUP));
  assign adv           = !s3_valid || bus.out_ready;
  assign bus.sym_ready = warm && adv;
  assign accept        = bus.sym_valid && bus.sym_ready;

  assign product       = s1_noise * $signed({1'b0, s1_scale});
  assign noise_shifted = product >>> SCALE_SHIFT;

  assign sum     = {{(SUM_W-DATA_W){s2_sym[DATA_W-1]}}, s2_sym}
                 + {{(SUM_W-33){s2_noise[32]}}, s2_noise};
  assign sat_hi  = (sum > MAX_V);
  assign sat_lo  = (sum < MIN_V);
  assign clamped = sat_hi ? MAX_V[DATA_W-1:0] :
                   sat_lo ? MIN_V[DATA_W-1:0] : sum[DATA_W-1:0];

  assign bus.out_data  = s3_data;
  assign bus.out_valid = s3_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wu_cnt <= '0;
    end else if (!warm) begin
      wu_cnt <= wu_cnt + WU_W'(1);
    end
  end

  // All three stages advance together; a stalled output freezes bubbles too.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_sym   <= '0;
      s1_noise <= '0;
      s1_scale <= '0;
      s1_valid <= 1'b0;
      s2_sym   <= '0;
      s2_noise <= '0;
      s2_valid <= 1'b0;
      s3_data  <= '0;
      s3_valid <= 1'b0;
    end else if (adv) begin
      s1_sym   <= bus.sym_in;
      s1_noise <= noise_en ? awgn_in : 16'sd0;
      s1_scale <= noise_scale;
      s1_valid <= accept;
      s2_sym   <= s1_sym;
      s2_noise <= noise_shifted;
      s2_valid <= s1_valid;
      s3_data  <= clamped;
      s3_valid <= s2_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_count <= '0;
      sat_count <= '0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        out_count <= out_count + 32'd1;
      end
      if (adv && s2_valid && (sat_hi || sat_lo) && (sat_count != 16'hFFFF)) begin
        sat_count <= sat_count + 16'd1;
      end
    end
  end

endmodule
